// File: rtl/exu_wb_pkg.sv
// rtl/exu_wb_pkg.sv - shared types and constants for the exu writeback responder
package exu_wb_pkg;

    localparam int          IRF_DATA_W       = 72;
    localparam int          IRF_RD_W         = 5;
    localparam int          STARVE_LIMIT_DEF = 3;
    localparam int          STALL_MAX_DEF    = 3;
    localparam logic [15:0] LFSR_SEED_DEF    = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RECOVER = 2'd3
    } wb_state_e;

    typedef enum logic {
        WIN_DIV     = 1'b0,
        WIN_RESTORE = 1'b1
    } wb_win_e;

    function automatic logic [1:0] stall_clip(input logic [1:0] raw, input logic [1:0] max);
        return (raw > max) ? max : raw;
    endfunction

endpackage

// File: rtl/exu_wb_lfsr.sv
// rtl/exu_wb_lfsr.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) driving injected stalls
module exu_wb_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic feedback;

    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/exu_wb_resp.sv
// rtl/exu_wb_resp.sv - div/restore writeback arbiter; EXU_WB_RESP_STALL_EN adds LFSR stalls
module exu_wb_resp
    import exu_wb_pkg::*;
#(
    parameter int          STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int          STALL_MAX    = STALL_MAX_DEF,
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_req,
    input  logic [IRF_DATA_W-1:0] div_data,
    input  logic [IRF_RD_W-1:0]   div_rd,
    input  logic                  restore_req,
    input  logic [IRF_DATA_W-1:0] restore_data,
    input  logic [IRF_RD_W-1:0]   restore_rd,
    output logic                  div_ack,
    output logic                  restore_ack,
    output logic                  irf_wen,
    output logic [IRF_DATA_W-1:0] irf_data,
    output logic [IRF_RD_W-1:0]   irf_rd,
    output logic                  proto_err
);

    localparam logic [1:0] STALL_MAX_L    = 2'(STALL_MAX);
    localparam logic [2:0] STARVE_LIMIT_L = 3'(STARVE_LIMIT);

    wb_state_e             state_q, state_d;
    wb_win_e               win_q, lat_win;
    logic [IRF_DATA_W-1:0] data_q, lat_data;
    logic [IRF_RD_W-1:0]   rd_q, lat_rd;
    logic [1:0]            stall_q, stall_d, stall_val;
    logic [2:0]            restore_wait_q;
    logic                  restore_wins, win_req, drop, enter_grant;

`ifdef EXU_WB_RESP_STALL_EN
    logic [15:0] lfsr;

    exu_wb_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign stall_val = stall_clip(lfsr[1:0], STALL_MAX_L);
`else
    assign stall_val = stall_clip(LFSR_SEED[1:0] & 2'b00, STALL_MAX_L);
`endif

    assign restore_wins = restore_req && (!div_req || (restore_wait_q >= STARVE_LIMIT_L));
    assign win_req      = (win_q == WIN_DIV) ? div_req : restore_req;
    assign enter_grant  = (state_d == ST_GRANT);

    always_comb begin
        state_d  = state_q;
        lat_win  = win_q;
        lat_data = data_q;
        lat_rd   = rd_q;
        stall_d  = stall_q;
        drop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (div_req || restore_req) begin
                    lat_win  = restore_wins ? WIN_RESTORE : WIN_DIV;
                    lat_data = restore_wins ? restore_data : div_data;
                    lat_rd   = restore_wins ? restore_rd : div_rd;
                    stall_d  = stall_val;
                    state_d  = (stall_val != 2'd0) ? ST_STALL : ST_GRANT;
                end
            end
            ST_STALL: begin
                // winner abandoning its request mid-stall is a protocol error
                if (!win_req) begin
                    drop    = 1'b1;
                    stall_d = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    stall_d = stall_q - 2'd1;
                    if (stall_q <= 2'd1) begin
                        stall_d = 2'd0;
                        state_d = ST_GRANT;
                    end
                end
            end
            ST_GRANT:   state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            win_q          <= WIN_DIV;
            data_q         <= '0;
            rd_q           <= '0;
            stall_q        <= 2'd0;
            restore_wait_q <= 3'd0;
            div_ack        <= 1'b0;
            restore_ack    <= 1'b0;
            irf_wen        <= 1'b0;
            irf_data       <= '0;
            irf_rd         <= '0;
            proto_err      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= lat_win;
            data_q      <= lat_data;
            rd_q        <= lat_rd;
            stall_q     <= stall_d;
            div_ack     <= enter_grant && (lat_win == WIN_DIV);
            restore_ack <= enter_grant && (lat_win == WIN_RESTORE);
            irf_wen     <= enter_grant;
            if (enter_grant) begin
                irf_data <= lat_data;
                irf_rd   <= lat_rd;
            end
            if (drop) begin
                proto_err <= 1'b1;
            end
            if (!restore_req || restore_ack) begin
                restore_wait_q <= 3'd0;
            end else if (restore_wait_q != 3'd7) begin
                restore_wait_q <= restore_wait_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_exu_wb_resp.sv
// tb/tb_exu_wb_resp.sv - directed bench for exu_wb_resp; EXU_WB_RESP_STALL_EN enables stall cases
module tb_exu_wb_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req;
    logic [71:0] div_data;
    logic [4:0]  div_rd;
    logic        restore_req;
    logic [71:0] restore_data;
    logic [4:0]  restore_rd;
    logic        div_ack;
    logic        restore_ack;
    logic        irf_wen;
    logic [71:0] irf_data;
    logic [4:0]  irf_rd;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    exu_wb_resp dut (
        .clk          (clk),
        .rst          (rst),
        .div_req      (div_req),
        .div_data     (div_data),
        .div_rd       (div_rd),
        .restore_req  (restore_req),
        .restore_data (restore_data),
        .restore_rd   (restore_rd),
        .div_ack      (div_ack),
        .restore_ack  (restore_ack),
        .irf_wen      (irf_wen),
        .irf_data     (irf_data),
        .irf_rd       (irf_rd),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    // reference LFSR, same seed and taps, tracked independently of the DUT
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct {
        logic        dq;
        logic [71:0] dd;
        logic [4:0]  dr;
        logic        rq;
        logic [71:0] rdat;
        logic [4:0]  rr;
        logic        exp_res;
        logic [71:0] exp_data;
        logic [4:0]  exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int exp_lat();
`ifdef EXU_WB_RESP_STALL_EN
        return 1 + int'((m_lfsr[1:0] > 2'd3) ? 2'd3 : m_lfsr[1:0]);
`else
        return 1;
`endif
    endfunction

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(div_ack || restore_ack) && n < 10);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, lat;
        logic [71:0] held;
        @(negedge clk);
        div_req = v.dq; div_data = v.dd; div_rd = v.dr;
        restore_req = v.rq; restore_data = v.rdat; restore_rd = v.rr;
        lat = exp_lat();
        wait_ack(n);
        chk($sformatf("v%0d_latency", idx), 72'(n), 72'(lat));
        chk($sformatf("v%0d_div_ack", idx), 72'(div_ack), 72'(!v.exp_res));
        chk($sformatf("v%0d_restore_ack", idx), 72'(restore_ack), 72'(v.exp_res));
        chk($sformatf("v%0d_wen", idx), 72'(irf_wen), 72'd1);
        chk($sformatf("v%0d_data", idx), irf_data, v.exp_data);
        chk($sformatf("v%0d_rd", idx), 72'(irf_rd), 72'(v.exp_rd));
        held = v.exp_data;
        div_req = 1'b0; restore_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_recover_wen", idx), 72'(irf_wen), 72'd0);
        chk($sformatf("v%0d_recover_acks", idx), 72'({div_ack, restore_ack}), 72'd0);
        chk($sformatf("v%0d_hold_data", idx), irf_data, held);
        @(negedge clk);
    endtask

    vec_t vecs[5];

    initial begin
        int n, lat, k;
        vecs[0] = '{1'b1, 72'h1, 5'd3, 1'b0, 72'h0, 5'd0, 1'b0, 72'h1, 5'd3};
        vecs[1] = '{1'b0, 72'h0, 5'd0, 1'b1, 72'hFF_DEAD_BEEF_0123_4567, 5'd31, 1'b1, 72'hFF_DEAD_BEEF_0123_4567, 5'd31};
        vecs[2] = '{1'b1, 72'h12_3456, 5'd9, 1'b1, 72'h65_4321, 5'd10, 1'b0, 72'h12_3456, 5'd9};
        vecs[3] = '{1'b1, {72{1'b1}}, 5'd0, 1'b0, 72'h5, 5'd4, 1'b0, {72{1'b1}}, 5'd0};
        vecs[4] = '{1'b0, 72'h7, 5'd1, 1'b1, 72'h80_0000_0000_0000_0001, 5'd16, 1'b1, 72'h80_0000_0000_0000_0001, 5'd16};

        rst = 1'b1; div_req = 1'b0; restore_req = 1'b0;
        div_data = '0; div_rd = '0; restore_data = '0; restore_rd = '0;
        repeat (3) @(negedge clk);
        chk("reset_acks", 72'({div_ack, restore_ack}), 72'd0);
        chk("reset_wen", 72'(irf_wen), 72'd0);
        chk("reset_data", irf_data, 72'd0);
        chk("reset_rd", 72'(irf_rd), 72'd0);
        chk("reset_proto_err", 72'(proto_err), 72'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

`ifndef EXU_WB_RESP_STALL_EN
        // both held: div, then restore once its wait reaches the limit, alternating
        div_req = 1'b1; div_data = 72'hD1; div_rd = 5'd2;
        restore_req = 1'b1; restore_data = 72'hE2; restore_rd = 5'd6;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("starve_div_ack_c%0d", i), 72'(div_ack),
                72'((i % 3 == 0) && ((i / 3) % 2 == 0)));
            chk($sformatf("starve_restore_ack_c%0d", i), 72'(restore_ack),
                72'((i % 3 == 0) && ((i / 3) % 2 == 1)));
            if (i == 3) chk("starve_restore_rd", 72'(irf_rd), 72'd6);
        end
        div_req = 1'b0; restore_req = 1'b0;
        repeat (2) @(negedge clk);
`endif

        // reset landing on a grant cycle, request still pending afterwards
        @(negedge clk);
        div_req = 1'b1; div_data = 72'hABC; div_rd = 5'd7;
        wait_ack(n);
        chk("rstgrant_first_ack", 72'(div_ack), 72'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstgrant_acks", 72'({div_ack, restore_ack}), 72'd0);
        chk("rstgrant_wen", 72'(irf_wen), 72'd0);
        chk("rstgrant_data", irf_data, 72'd0);
        chk("rstgrant_rd", 72'(irf_rd), 72'd0);
        rst = 1'b0;
        lat = exp_lat();
        wait_ack(n);
        chk("rstgrant_relatency", 72'(n), 72'(lat));
        chk("rstgrant_redata", irf_data, 72'hABC);
        chk("rstgrant_rerd", 72'(irf_rd), 72'd7);
        div_req = 1'b0;
        repeat (2) @(negedge clk);

`ifdef EXU_WB_RESP_STALL_EN
        // maximum stall: request sampled when the LFSR low bits are 3
        k = 0;
        while (m_lfsr[1:0] != 2'd3 && k < 200) begin @(negedge clk); k++; end
        restore_req = 1'b1; restore_data = 72'h33; restore_rd = 5'd12;
        wait_ack(n);
        chk("stall_max_latency", 72'(n), 72'd4);
        chk("stall_max_ack", 72'(restore_ack), 72'd1);
        restore_req = 1'b0;
        repeat (2) @(negedge clk);

        k = 0;
        while (m_lfsr[1:0] != 2'd3 && k < 200) begin @(negedge clk); k++; end
        restore_req = 1'b1;
        @(negedge clk);
        restore_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drop_no_ack_c%0d", i), 72'({div_ack, restore_ack, irf_wen}), 72'd0);
        end
        chk("drop_proto_err", 72'(proto_err), 72'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("drop_proto_err_cleared", 72'(proto_err), 72'd0);
`endif

        chk("final_proto_err", 72'(proto_err), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_wb_resp.md
EXU_WB_RESP -- requirements
Module: exu_wb_resp

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: restore wait cycles after which restore beats div in arbitration.
REQ-002 Parameter STALL_MAX, default 3: maximum injected stall cycles; legal range 0..3.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: reset value of the stall LFSR; must be nonzero.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 div_req  input  1  divider writeback request; level, held until acknowledged.
REQ-007 div_data  input  72  divider result with ECC.
REQ-008 div_rd  input  5  divider destination register.
REQ-009 restore_req  input  1  restore writeback request; level, held until acknowledged.
REQ-010 restore_data  input  72  restore data with ECC.
REQ-011 restore_rd  input  5  restore destination register.
REQ-012 div_ack  output  1  one-cycle grant pulse to the divider.
REQ-013 restore_ack  output  1  one-cycle grant pulse to restore.
REQ-014 irf_wen  output  1  register-file write enable.
REQ-015 irf_data  output  72  register-file write data.
REQ-016 irf_rd  output  5  register-file write address.
REQ-017 proto_err  output  1  sticky flag: a request dropped before its acknowledge.

Function
REQ-018 FSM states: IDLE, STALL, GRANT, RECOVER.
REQ-019 IDLE with any request: latch winner, data and rd; go to STALL if the stall count is nonzero, else to GRANT.
REQ-020 Arbitration: div wins; restore wins if restore_wait >= STARVE_LIMIT or div_req is low.
REQ-021 restore_wait is a 3-bit counter: increments (saturating at 7) each cycle restore_req is high and restore is not granted; clears when restore_req is low or restore is granted.
REQ-022 STALL: decrement the stall counter each cycle; go to GRANT when it reaches 0.
REQ-023 GRANT lasts one cycle: winner's ack=1, irf_wen=1, irf_data/irf_rd=latched values; next state RECOVER.
REQ-024 RECOVER lasts one cycle: all requests ignored, so the requester may drop its request; next state IDLE.
REQ-025 Latency with no stall: request sampled in IDLE at edge N; ack and irf_wen high in cycle N+1; a new request is sampled at edge N+3.
REQ-026 All outputs are registered; acks and irf_wen are never high outside GRANT.
REQ-027 If the winner's request is low during STALL: go to IDLE, no ack, no write, set proto_err.
REQ-028 irf_data/irf_rd hold their last value when irf_wen=0.
REQ-029 Data carrying X is passed through unmodified; X detection is outside this block.

Reset
REQ-030 rst at any edge, including mid-STALL or GRANT: FSM=IDLE, all outputs 0, restore_wait=0, stall counter=0, LFSR=LFSR_SEED, proto_err=0, effective the next cycle.

Configuration
REQ-031 With EXU_WB_RESP_STALL_EN defined, the stall count is LFSR[1:0] clipped to STALL_MAX, taken at each IDLE-to-grant decision; the LFSR advances every cycle.
REQ-032 Without EXU_WB_RESP_STALL_EN, the LFSR is not built, the stall count is always 0 and the STALL state is unreachable.

Structure
REQ-033 Package exu_wb_pkg holds the FSM state enum, IRF_DATA_W=72, IRF_RD_W=5 and the default parameter constants.
REQ-034 Sub-module exu_wb_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11), seed parameter, synchronous reset; it is instantiated only under EXU_WB_RESP_STALL_EN.

Verification
REQ-035 No stall; div_req with data=72'h1, rd=3 at edge N -> div_ack=1, irf_wen=1, irf_rd=3, irf_data=72'h1 in cycle N+1; idle by N+3.
REQ-036 div_req and restore_req both held continuously -> div granted; restore granted no later than the arbitration after restore_wait reaches 3; no request waits more than 5 cycles.
REQ-037 Stall enabled, seed forced so that LFSR[1:0]=3 -> ack arrives 4 cycles after sampling, never more than 5.
REQ-038 restore_req dropped during STALL -> no ack, no write, proto_err=1 until rst.
REQ-039 rst asserted in a GRANT cycle -> all outputs 0 next cycle, and the pending request is re-arbitrated from IDLE.
